mux4x2_8bits: RTL and testbench
===============================

# mux4x2_8bits

Transmit-side counterpart of the four-lane 8-bit demultiplexer: it takes four 8-bit channels, each with a valid flag, and serializes them onto two 8-bit lanes at twice the channel rate. Lane 00 carries channels 0 and 1 interleaved; lane 11 carries channels 2 and 3 interleaved. The lane pair matches, byte for byte, the input ordering the receive-side demux expects, so the two blocks can be connected back to back for loopback. The block runs entirely on the fast clock and generates its own half-rate phase internally.

## Interface
Parameters:
- IDLE_BYTE, 8'hBC: byte driven on a lane slot whose channel is invalid (only when IDLE_FILL_EN is defined).

Ports:
- clk_2f  input  1  lane-rate clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_tx0 / data_tx1 / data_tx2 / data_tx3  input  8 each  channel data, sampled only on phase-0 edges.
- valid_tx0 / valid_tx1 / valid_tx2 / valid_tx3  input  1 each  channel valid, sampled with its data.
- data_tx00  output  8  lane 00: ch0 slot, then ch1 slot.
- data_tx11  output  8  lane 11: ch2 slot, then ch3 slot.
- valid_tx00 / valid_tx11  output  1 each  valid for the current slot on each lane.
- frame_tx  output  1  high while the lanes carry the ch0/ch2 slot, low for the ch1/ch3 slot.
- phase_f  output  1  internal half-rate phase (equivalent of clk_f). Upstream logic uses it to time input updates.

## Operation
- Phase register `phase` toggles on every clk_2f edge when reset is low.
- Edge with phase==0 (sample edge):
  - Capture all four data/valid pairs into cap0..cap3.
  - Load the lane outputs directly: lane 00 <= data_tx0/valid_tx0, lane 11 <= data_tx2/valid_tx2, frame_tx <= 1.
- Edge with phase==1:
  - Load lane 00 <= cap1, lane 11 <= cap3, frame_tx <= 0.
  - cap0 and cap2 hold their values and are unused.
- Inputs are ignored on phase==1 edges. A change in that window is not seen until the next sample edge.
- Valid is per slot. A lane can carry a valid ch0 slot and an invalid ch1 slot.
- Data is passed through unmodified. There is no width conversion or arithmetic.
- Reset, on any edge, including mid-frame: phase, cap0..cap3 and all outputs clear to 0. The first edge after reset deasserts is a sample edge.

## Timing
- Reset values: data_tx00 = data_tx11 = 8'h00; valid_tx00 = valid_tx11 = 0; frame_tx = 0; phase_f = 0.
- Latency: a ch0/ch2 byte appears 1 clk_2f cycle after its sample edge. A ch1/ch3 byte appears 2 cycles after its sample edge.
- Each slot is held for exactly 1 clk_2f cycle. The frame period is 2 cycles.
- Throughput: 4 bytes per 2 clk_2f cycles. There is no backpressure and no stall.
- phase_f reads 0 during the cycle that precedes a sample edge. Upstream must hold channel inputs stable across that edge.
- Reset released mid-frame: the frame in flight is dropped, with no partial slot output. Normal output resumes 1 cycle after the first sample edge.

## Configuration
- IDLE_FILL_EN defined:
  - Any slot whose captured valid is 0 drives IDLE_BYTE on its lane data, with valid low.
  - Reset values are unchanged (8'h00).
- IDLE_FILL_EN undefined:
  - Lane data carries the captured channel byte regardless of valid.
  - Valid still goes low for invalid slots.

## Test plan
- Reset, then hold reset high for 3 cycles -> all outputs 0 and phase_f 0 throughout. The first sample edge occurs on the first edge after release.
- Drive ch0..3 = 8'h11/22/33/44, all valid -> lane 00 shows 11 then 22, lane 11 shows 33 then 44, frame_tx shows 1 then 0, valid_tx00/valid_tx11 high in both slots.
- Change the inputs to 8'hAA..DD during a phase==1 edge only -> that frame still shows 11/22/33/44. The new values appear at the next sample edge.
- Set valid_tx1 = 0 with data_tx1 = 8'h55 -> the lane 00 ch1 slot has valid 0 and data 55. With IDLE_FILL_EN defined, the same slot shows data BC.
- Assert reset for 1 cycle between the ch0 slot and the ch1 slot -> the next cycle shows all outputs 0 and no ch1 byte. Output restarts with the ch0/ch2 slot.
- Loopback into the receive-side demux with a counting pattern over 64 frames -> the demux outputs equal the mux inputs, delayed by a fixed latency, with no reordering.

Source files
------------

// File: rtl/mux4x2_8bits.sv
// -----------------------------------------------------------------------------
// mux4x2_8bits
//
// Transmit-side 4:2 byte serializer. Four 8-bit channels, each with a valid
// flag, go out on two 8-bit lanes at twice the channel rate:
//   lane 00 : ch0 slot, then ch1 slot
//   lane 11 : ch2 slot, then ch3 slot
// The block runs on the fast clock only and makes its own half-rate phase.
//
// Ports
//   clk_2f                 in   lane-rate clock, rising edge
//   reset                  in   synchronous, active-high reset
//   data_tx0..data_tx3     in   channel data, sampled on phase-0 edges only
//   valid_tx0..valid_tx3   in   channel valid, sampled with its data
//   data_tx00, valid_tx00  out  lane 00 slot data / valid
//   data_tx11, valid_tx11  out  lane 11 slot data / valid
//   frame_tx               out  1 during the ch0/ch2 slot, 0 during ch1/ch3
//   phase_f                out  internal half-rate phase (clk_f equivalent)
//
// Build option
//   IDLE_FILL_EN  when defined, an invalid slot drives IDLE_BYTE on its lane
//                 data instead of the captured byte (valid stays low).
// -----------------------------------------------------------------------------
module mux4x2_8bits #(
    parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_tx0,
    input  logic [7:0] data_tx1,
    input  logic [7:0] data_tx2,
    input  logic [7:0] data_tx3,
    input  logic       valid_tx0,
    input  logic       valid_tx1,
    input  logic       valid_tx2,
    input  logic       valid_tx3,
    output logic [7:0] data_tx00,
    output logic [7:0] data_tx11,
    output logic       valid_tx00,
    output logic       valid_tx11,
    output logic       frame_tx,
    output logic       phase_f
);

    // Gather the channels so each lane can index its pair generically.
    logic [7:0] ch_data [4];
    logic [3:0] ch_valid;

    assign ch_data[0] = data_tx0;
    assign ch_data[1] = data_tx1;
    assign ch_data[2] = data_tx2;
    assign ch_data[3] = data_tx3;
    assign ch_valid   = {valid_tx3, valid_tx2, valid_tx1, valid_tx0};

    // Phase 0 marks the sample edge. After reset the phase is 0, so the
    // first edge with reset low is always a sample edge.
    logic phase_q, phase_d;
    logic frame_q, frame_d;

    always_comb begin
        phase_d = ~phase_q;
        // frame_tx goes high exactly when the ch0/ch2 slot is loaded.
        frame_d = ~phase_q;
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            phase_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            frame_q <= frame_d;
        end
    end

    // One lane per generate iteration: lane gi carries channels 2*gi
    // (first slot) and 2*gi+1 (second slot). The first-slot channel goes
    // straight to the lane register on the sample edge, so only the
    // second-slot channel needs a holding register for the following edge.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] cap_data_q, cap_data_d;
            logic       cap_valid_q, cap_valid_d;
            logic [7:0] data_q, data_d;
            logic       valid_q, valid_d;
            logic [7:0] slot_data;
            logic       slot_valid;

            always_comb begin
                cap_data_d  = cap_data_q;
                cap_valid_d = cap_valid_q;
                slot_data   = cap_data_q;
                slot_valid  = cap_valid_q;
                if (!phase_q) begin
                    cap_data_d  = ch_data[2*gi+1];
                    cap_valid_d = ch_valid[2*gi+1];
                    slot_data   = ch_data[2*gi];
                    slot_valid  = ch_valid[2*gi];
                end
                valid_d = slot_valid;
`ifdef IDLE_FILL_EN
                data_d = slot_valid ? slot_data : IDLE_BYTE;
`else
                data_d = slot_data;
`endif
            end

            always_ff @(posedge clk_2f) begin
                if (reset) begin
                    cap_data_q  <= 8'h00;
                    cap_valid_q <= 1'b0;
                    data_q      <= 8'h00;
                    valid_q     <= 1'b0;
                end else begin
                    cap_data_q  <= cap_data_d;
                    cap_valid_q <= cap_valid_d;
                    data_q      <= data_d;
                    valid_q     <= valid_d;
                end
            end
        end
    endgenerate

`ifndef IDLE_FILL_EN
    // IDLE_BYTE only matters when idle fill is built in.
    logic [7:0] idle_byte_unused;
    assign idle_byte_unused = IDLE_BYTE;
`endif

    assign data_tx00  = g_lane[0].data_q;
    assign valid_tx00 = g_lane[0].valid_q;
    assign data_tx11  = g_lane[1].data_q;
    assign valid_tx11 = g_lane[1].valid_q;
    assign frame_tx   = frame_q;
    assign phase_f    = phase_q;

endmodule

// File: tb/tb_mux4x2_8bits.sv
module tb_mux4x2_8bits;

    logic       clk_2f = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] data_tx0 = 8'h00, data_tx1 = 8'h00, data_tx2 = 8'h00, data_tx3 = 8'h00;
    logic       valid_tx0 = 1'b0, valid_tx1 = 1'b0, valid_tx2 = 1'b0, valid_tx3 = 1'b0;
    logic [7:0] data_tx00, data_tx11;
    logic       valid_tx00, valid_tx11, frame_tx, phase_f;

    mux4x2_8bits dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .data_tx0   (data_tx0),
        .data_tx1   (data_tx1),
        .data_tx2   (data_tx2),
        .data_tx3   (data_tx3),
        .valid_tx0  (valid_tx0),
        .valid_tx1  (valid_tx1),
        .valid_tx2  (valid_tx2),
        .valid_tx3  (valid_tx3),
        .data_tx00  (data_tx00),
        .data_tx11  (data_tx11),
        .valid_tx00 (valid_tx00),
        .valid_tx11 (valid_tx11),
        .frame_tx   (frame_tx),
        .phase_f    (phase_f)
    );

    always #5 clk_2f = ~clk_2f;

`ifdef IDLE_FILL_EN
    localparam bit IDLE_ON = 1'b1;
`else
    localparam bit IDLE_ON = 1'b0;
`endif

    // Expected lane byte for an invalid slot whose channel carried x.
    function automatic logic [7:0] fill(input logic [7:0] x);
        return IDLE_ON ? 8'hBC : x;
    endfunction

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [7:0]  d00;
        logic        v00;
        logic [7:0]  d11;
        logic        v11;
        logic        fr;
        logic        ph;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk_2f) cyc <= cyc + 1;

    // Monitor: the outputs are presented every cycle; compare whatever
    // expectation is tagged for the cycle that just completed.
    always @(posedge clk_2f) begin
        #1;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (data_tx00 !== e.d00 || valid_tx00 !== e.v00 ||
                         data_tx11 !== e.d11 || valid_tx11 !== e.v11 ||
                         frame_tx !== e.fr || phase_f !== e.ph) begin
                bad++;
                $display("FAIL %s: got d00=%h v00=%b d11=%h v11=%b fr=%b ph=%b want d00=%h v00=%b d11=%h v11=%b fr=%b ph=%b",
                         e.name, data_tx00, valid_tx00, data_tx11, valid_tx11, frame_tx, phase_f,
                         e.d00, e.v00, e.d11, e.v11, e.fr, e.ph);
            end else begin
                $display("ok   %s: d00=%h v00=%b d11=%h v11=%b fr=%b ph=%b",
                         e.name, data_tx00, valid_tx00, data_tx11, valid_tx11, frame_tx, phase_f);
            end
        end
    end

    // Drive one cycle of inputs and push the outputs expected after the
    // coming rising edge.
    task automatic step(input string name, input logic rst,
                        input logic [7:0] i0, input logic [7:0] i1,
                        input logic [7:0] i2, input logic [7:0] i3,
                        input logic [3:0] iv,
                        input logic [7:0] e00, input logic ev00,
                        input logic [7:0] e11, input logic ev11,
                        input logic ef, input logic ep);
        exp_t e;
        @(negedge clk_2f);
        reset     = rst;
        data_tx0  = i0;
        data_tx1  = i1;
        data_tx2  = i2;
        data_tx3  = i3;
        valid_tx0 = iv[0];
        valid_tx1 = iv[1];
        valid_tx2 = iv[2];
        valid_tx3 = iv[3];
        e.cyc  = cyc + 1;
        e.name = name;
        e.d00  = e00;
        e.v00  = ev00;
        e.d11  = e11;
        e.v11  = ev11;
        e.fr   = ef;
        e.ph   = ep;
        sb.push_back(e);
    endtask

    initial begin
        logic [7:0] b;

        // Reset held for three cycles, with busy inputs: outputs stay 0.
        for (int i = 0; i < 3; i++)
            step("reset", 1'b1, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 4'hF,
                 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // First edge after release is a sample edge.
        step("basic_s0", 1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 4'hF,
             8'h11, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
        // Inputs change on the phase-1 edge only: still 22/44 from capture.
        step("basic_s1", 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF,
             8'h22, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        step("new_s0", 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF,
             8'hAA, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1);
        step("new_s1", 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF,
             8'hBB, 1'b1, 8'hDD, 1'b1, 1'b0, 1'b0);

        // ch1 invalid with data 55.
        step("inv1_s0", 1'b0, 8'h11, 8'h55, 8'h33, 8'h44, 4'b1101,
             8'h11, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
        step("inv1_s1", 1'b0, 8'h11, 8'h55, 8'h33, 8'h44, 4'b1101,
             fill(8'h55), 1'b0, 8'h44, 1'b1, 1'b0, 1'b0);

        // ch0 and ch3 invalid: direct path and captured path both.
        step("inv03_s0", 1'b0, 8'h66, 8'h77, 8'h88, 8'h99, 4'b0110,
             fill(8'h66), 1'b0, 8'h88, 1'b1, 1'b1, 1'b1);
        step("inv03_s1", 1'b0, 8'h66, 8'h77, 8'h88, 8'h99, 4'b0110,
             8'h77, 1'b1, fill(8'h99), 1'b0, 1'b0, 1'b0);

        // Reset between the ch0 slot and the ch1 slot drops the frame.
        step("mid_s0", 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 4'hF,
             8'h01, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        step("mid_rst", 1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 4'hF,
             8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("restart_s0", 1'b0, 8'h05, 8'h06, 8'h07, 8'h08, 4'hF,
             8'h05, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        step("restart_s1", 1'b0, 8'h05, 8'h06, 8'h07, 8'h08, 4'hF,
             8'h06, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0);

        // Counting pattern: ordering and lane mapping over many frames.
        for (int k = 0; k < 16; k++) begin
            b = 8'(4 * k + 8'h20);
            step("count_s0", 1'b0, b, b + 8'd1, b + 8'd2, b + 8'd3, 4'hF,
                 b, 1'b1, b + 8'd2, 1'b1, 1'b1, 1'b1);
            step("count_s1", 1'b0, b, b + 8'd1, b + 8'd2, b + 8'd3, 4'hF,
                 b + 8'd1, 1'b1, b + 8'd3, 1'b1, 1'b0, 1'b0);
        end

        // Let the monitor drain; anything left over was never checked.
        repeat (3) @(negedge clk_2f);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
